// File: rtl/acc_cpu_param.sv
// Multicycle accumulator CPU (8-op ISA, direct/indirect operands) on one shared memory port.
// Latency: 2 cycles per direct instruction, 3 per indirect, with mem_ack tied high.
// Backpressure: each memory state holds mem_req with stable addr/we/wdata until mem_ack.
module acc_cpu_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 13,
  parameter int IND_PTR = 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] w,
  output logic              instr_done,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam int LG = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] C_IND_PTR = ADDR_W'(IND_PTR);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_NOR   = 3'b001;
  localparam logic [2:0] OP_SHIFT = 3'b010;
  localparam logic [2:0] OP_GT    = 3'b011;
  localparam logic [2:0] OP_SKIP  = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_JUMP  = 3'b111;

  // Operand region selectors for the shift op: region index is M / DATA_W.
  localparam logic [DATA_W-LG-1:0] C_HI1 = {{(DATA_W-LG-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-LG-1:0] C_HI2 = {{(DATA_W-LG-2){1'b0}}, 2'b10};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PTR   = 3'd2,
    S_OPER  = 3'd3,
    S_STORE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_ea;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_w;
  logic [CNT_W-1:0]    r_cnt;

  logic [2:0]          w_fetch_op;
  logic [ADDR_W-1:0]   w_fetch_a;
  logic                w_req;
  logic                w_we;
  logic                w_retire;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  logic [LG-1:0]        w_sh;
  logic [DATA_W-LG-1:0] w_hi;
  logic [2*DATA_W-1:0]  w_dbl;
  logic [DATA_W-1:0]    w_ror;
  logic [DATA_W-1:0]    w_rol;
  logic [DATA_W-1:0]    w_shift_res;
  logic [DATA_W-1:0]    w_w_nxt;
  logic [ADDR_W-1:0]    w_pc_nxt;

  assign w_fetch_op = mem_rdata[DATA_W-1:DATA_W-3];
  assign w_fetch_a  = mem_rdata[ADDR_W-1:0];

  // Every shift amount reduces to M mod DATA_W because DATA_W is a power of two.
  assign w_sh  = mem_rdata[LG-1:0];
  assign w_hi  = mem_rdata[DATA_W-1:LG];
  assign w_dbl = {r_w, r_w};
  assign w_ror = DATA_W'(w_dbl >> w_sh);
  assign w_rol = DATA_W'((w_dbl << w_sh) >> DATA_W);

  // Shift op: logical right, logical left, rotate right, rotate left by operand region.
  always_comb begin
    w_shift_res = w_rol;
    if (w_hi == '0)
      w_shift_res = r_w >> w_sh;
    else if (w_hi == C_HI1)
      w_shift_res = r_w << w_sh;
    else if (w_hi == C_HI2)
      w_shift_res = w_ror;
  end

  // Execute: next accumulator and pc for the instruction retiring this cycle.
  always_comb begin
    w_w_nxt  = r_w;
    w_pc_nxt = r_pc + ADDR_W'(1);
    case (r_op)
      OP_ADD:   w_w_nxt = r_w + mem_rdata;
      OP_NOR:   w_w_nxt = ~(r_w | mem_rdata);
      OP_SHIFT: w_w_nxt = w_shift_res;
      OP_GT:    w_w_nxt = {{(DATA_W-1){1'b0}}, (r_w > mem_rdata)};
      OP_SKIP:  w_pc_nxt = (mem_rdata == '0) ? r_pc + ADDR_W'(2) : r_pc + ADDR_W'(1);
      OP_LOAD:  w_w_nxt = mem_rdata;
      OP_JUMP:  w_pc_nxt = mem_rdata[ADDR_W-1:0];
      default:  w_w_nxt = r_w;
    endcase
  end

  // Next-state and memory-port control; each memory state waits for mem_ack.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (mem_ack) begin
          if (w_fetch_a == '0)           w_state_nxt = S_PTR;
          else if (w_fetch_op == OP_STORE) w_state_nxt = S_STORE;
          else                           w_state_nxt = S_OPER;
        end
      end
      S_PTR: begin
        w_req  = 1'b1;
        w_addr = C_IND_PTR;
        if (mem_ack) w_state_nxt = (r_op == OP_STORE) ? S_STORE : S_OPER;
      end
      S_OPER: begin
        w_req  = 1'b1;
        w_addr = r_ea;
        if (mem_ack) begin
          w_retire    = 1'b1;
          w_state_nxt = run ? S_FETCH : S_IDLE;
        end
      end
      S_STORE: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_ea;
        w_wdata = r_w;
        if (mem_ack) begin
          w_retire    = 1'b1;
          w_state_nxt = run ? S_FETCH : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, decoded instruction, effective address and architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_ea    <= '0;
      r_pc    <= '0;
      r_w     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FETCH && mem_ack) begin
        r_op <= w_fetch_op;
        r_ea <= w_fetch_a;
      end
      if (r_state == S_PTR && mem_ack)
        r_ea <= mem_rdata[ADDR_W-1:0];
      if (w_retire) begin
        r_pc  <= w_pc_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_state == S_OPER) r_w <= w_w_nxt;
      end
    end
  end

  // Port drive is forced quiet while reset is held, abandoning any open transaction.
  assign mem_req    = w_req & ~rst;
  assign mem_we     = w_we & ~rst;
  assign mem_addr   = rst ? '0 : w_addr;
  assign mem_wdata  = rst ? '0 : w_wdata;
  assign instr_done = w_retire & ~rst;
  assign pc         = r_pc;
  assign w          = r_w;
  assign instr_cnt  = r_cnt;

endmodule
